// File: rtl/bram_pkg.sv
// Shared types and helpers for the parametrised simple-dual-port block RAM.
// Holds the read-during-write and clear-engine enums and the pattern replicator.
package bram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_e;

  localparam int MAX_DATA_W = 1024;

  // Fills the low n_bytes bytes with pat; the caller slices to its own width.
  function automatic logic [MAX_DATA_W-1:0] replicate_pattern(
    input logic [7:0] pat,
    input int         n_bytes
  );
    logic [MAX_DATA_W-1:0] word;
    word = '0;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (i < n_bytes) word[8*i +: 8] = pat;
    end
    return word;
  endfunction

endpackage

// File: rtl/bram_sdp_param_if.sv
// Bus bundle for bram_sdp_param: write port, read port, clear control and debug state.
// The master side is the capture/upload logic; the slave side is the RAM.
interface bram_sdp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  import bram_pkg::*;

  // Request/response semantics: WR_EN, RD_EN and CLR_REQ are single-cycle
  // requests sampled on every rising edge with no ready/backpressure; the RAM
  // answers with one-cycle pulses (RD_VALID per accepted read, WR_DROP per
  // discarded write) while CLR_BUSY is a level covering the whole clear.
  logic                  WR_EN;
  logic [ADDR_W-1:0]     WR_ADDR;
  logic [DATA_W/8-1:0]   WR_BE;
  logic [DATA_W-1:0]     WR_DATA;
  logic                  WR_DROP;
  logic                  RD_EN;
  logic [ADDR_W-1:0]     RD_ADDR;
  logic [DATA_W-1:0]     RD_DATA;
  logic                  RD_VALID;
  logic                  CLR_REQ;
  logic                  CLR_BUSY;
  clr_state_e            DBG_CLR_STATE;

  modport master (
    output WR_EN, WR_ADDR, WR_BE, WR_DATA, RD_EN, RD_ADDR, CLR_REQ,
    input  WR_DROP, RD_DATA, RD_VALID, CLR_BUSY, DBG_CLR_STATE
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_BE, WR_DATA, RD_EN, RD_ADDR, CLR_REQ,
    output WR_DROP, RD_DATA, RD_VALID, CLR_BUSY, DBG_CLR_STATE
  );

endinterface

// File: rtl/bram_clear_fsm.sv
// Clear engine: walks every address once, one word per cycle, while it owns the write port.
// Reset either parks it in IDLE or relaunches a full clear from address 0.
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int DEPTH          = 2048,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output clr_state_e        o_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR_ON_RESET ? CLEARING : IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A request arriving while a clear is running is simply not looked at.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEARING;
          w_cnt_nxt   = '0;
        end
      end
      CLEARING: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy  = (r_state == CLEARING);
  assign o_addr  = r_cnt;
  assign o_state = r_state;

endmodule

// File: rtl/bram_sdp_param.sv
// Parametrised simple-dual-port block RAM with byte enables, read-during-write select,
// 1- or 2-cycle read latency with a valid flag, and a hardware clear engine.
module bram_sdp_param
  import bram_pkg::*;
#(
  parameter int         DATA_W         = 8,
  parameter int         DEPTH          = 2048,
  parameter int         ADDR_W         = $clog2(DEPTH),
  parameter int         RD_LATENCY     = 1,
  parameter rdw_mode_e  RDW_MODE       = WRITE_FIRST,
  parameter logic [7:0] INIT_PATTERN   = 8'h5A,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input logic             CLK,
  input logic             RST,
  bram_sdp_param_if.slave bus
);

  localparam int                    NB        = DATA_W / 8;
  localparam logic [MAX_DATA_W-1:0] INIT_FULL = replicate_pattern(INIT_PATTERN, NB);
  localparam logic [DATA_W-1:0]     INIT_WORD = INIT_FULL[DATA_W-1:0];
  localparam logic [ADDR_W:0]       DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("bram_sdp_param: DATA_W must be a multiple of 8 between 8 and %0d", MAX_DATA_W);
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("bram_sdp_param: RD_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("bram_sdp_param: DEPTH must be at least 2");
  end

  logic              w_clr_busy;
  logic [ADDR_W-1:0] w_clr_addr;
  clr_state_e        w_clr_state;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_clr_we;
  logic              w_user_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [NB-1:0]     w_wbe;
  logic [DATA_W-1:0] w_wdata;
  logic              w_collide;
  logic [DATA_W-1:0] w_rd_old;
  logic [DATA_W-1:0] w_rd_word;
  logic              r_wr_drop;
  logic              r_rd_valid1;
  logic [DATA_W-1:0] r_rd_data1;

  // Contents start as the replicated pattern; reset never touches the array.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: INIT_WORD};

  bram_clear_fsm #(
    .DEPTH         (DEPTH),
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_fsm (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clr_req(bus.CLR_REQ),
    .o_busy   (w_clr_busy),
    .o_addr   (w_clr_addr),
    .o_state  (w_clr_state)
  );

  assign w_wr_in_range = ({1'b0, bus.WR_ADDR} < DEPTH_X);
  assign w_rd_in_range = ({1'b0, bus.RD_ADDR} < DEPTH_X);

  // Write-port override: the clear engine wins outright while busy. Nothing
  // lands in the array on a reset edge, which is what aborts a clear cleanly.
  assign w_clr_we  = w_clr_busy && !RST;
  assign w_user_we = bus.WR_EN && !w_clr_busy && w_wr_in_range && !RST;
  assign w_we      = w_clr_we || w_user_we;
  assign w_waddr   = w_clr_busy ? w_clr_addr : bus.WR_ADDR;
  assign w_wbe     = w_clr_busy ? {NB{1'b1}} : bus.WR_BE;
  assign w_wdata   = w_clr_busy ? INIT_WORD : bus.WR_DATA;

  always_ff @(posedge CLK) begin
    if (w_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wbe[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= bus.WR_EN && (w_clr_busy || !w_wr_in_range);
    end
  end

  assign w_rd_old  = w_rd_in_range ? r_mem[bus.RD_ADDR] : '0;
  assign w_collide = w_we && w_rd_in_range && (w_waddr == bus.RD_ADDR);

  // Write-first collisions return the merged word, byte by byte.
  always_comb begin
    w_rd_word = w_rd_old;
    if (RDW_MODE == WRITE_FIRST && w_collide) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wbe[b]) w_rd_word[8*b +: 8] = w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_valid1 <= 1'b0;
      r_rd_data1  <= '0;
    end else begin
      r_rd_valid1 <= bus.RD_EN;
      if (bus.RD_EN) r_rd_data1 <= w_rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              r_rd_valid2;
    logic [DATA_W-1:0] r_rd_data2;

    // Stage two advances on its own valid, so results drain after RD_EN drops.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_rd_valid2 <= 1'b0;
        r_rd_data2  <= '0;
      end else begin
        r_rd_valid2 <= r_rd_valid1;
        if (r_rd_valid1) r_rd_data2 <= r_rd_data1;
      end
    end

    assign bus.RD_VALID = r_rd_valid2;
    assign bus.RD_DATA  = r_rd_data2;
  end else begin : g_lat1
    assign bus.RD_VALID = r_rd_valid1;
    assign bus.RD_DATA  = r_rd_data1;
  end

  assign bus.WR_DROP       = r_wr_drop;
  assign bus.CLR_BUSY      = w_clr_busy;
  assign bus.DBG_CLR_STATE = w_clr_state;

endmodule

// File: tb/tb_bram_sdp_param.sv
// Bench for bram_sdp_param: two 32x1000 instances (A: latency 1, write-first, no clear on
// reset; B: latency 2, read-first, clear on reset) share stimulus and a behavioural model.
module tb_bram_sdp_param;
  import bram_pkg::*;

  localparam int          DW    = 32;
  localparam int          DEPTH = 1000;
  localparam int          AW    = 10;
  localparam logic [31:0] PAT   = 32'h5A5A5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          clr_req;

  bram_sdp_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  bram_sdp_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  assign bus_a.WR_EN = wr_en;   assign bus_b.WR_EN = wr_en;
  assign bus_a.WR_ADDR = wr_addr; assign bus_b.WR_ADDR = wr_addr;
  assign bus_a.WR_BE = wr_be;   assign bus_b.WR_BE = wr_be;
  assign bus_a.WR_DATA = wr_data; assign bus_b.WR_DATA = wr_data;
  assign bus_a.RD_EN = rd_en;   assign bus_b.RD_EN = rd_en;
  assign bus_a.RD_ADDR = rd_addr; assign bus_b.RD_ADDR = rd_addr;
  assign bus_a.CLR_REQ = clr_req; assign bus_b.CLR_REQ = clr_req;

  bram_sdp_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .RD_LATENCY(1), .RDW_MODE(WRITE_FIRST),
    .INIT_PATTERN(8'h5A), .CLEAR_ON_RESET(1'b0)
  ) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));

  bram_sdp_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .RD_LATENCY(2), .RDW_MODE(READ_FIRST),
    .INIT_PATTERN(8'h5A), .CLEAR_ON_RESET(1'b1)
  ) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (index 0 = A, 1 = B) ----------------
  logic [31:0] m_mem [2][DEPTH];
  bit          m_clr_on [2];
  int          m_clr_pos [2];
  bit          m_drop [2];
  bit          m_valid [2];
  logic [31:0] m_data [2];
  logic [63:0] exp_q_a[$];   // {due edge, data}
  logic [63:0] exp_q_b[$];
  int          cyc = 0;
  bit          started = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_step(input int d);
    bit          wdo, ndrop;
    int          wa, lat;
    logic [31:0] wd, r;
    logic [3:0]  wbe;
    logic [63:0] e;
    lat = (d == 0) ? 1 : 2;
    if (rst) begin
      if (d == 0) exp_q_a.delete(); else exp_q_b.delete();
      m_valid[d] = 0; m_data[d] = '0; m_drop[d] = 0;
      m_clr_on[d] = (d == 1); m_clr_pos[d] = 0;
      return;
    end
    wdo = 0; wa = 0; wd = '0; wbe = '0;
    if (m_clr_on[d]) begin
      wdo = 1; wa = m_clr_pos[d]; wd = PAT; wbe = 4'hF;
    end else if (wr_en && int'(wr_addr) < DEPTH) begin
      wdo = 1; wa = int'(wr_addr); wd = wr_data; wbe = wr_be;
    end
    ndrop = wr_en && (m_clr_on[d] || int'(wr_addr) >= DEPTH);
    if (rd_en) begin
      if (int'(rd_addr) >= DEPTH) r = '0;
      else begin
        r = m_mem[d][int'(rd_addr)];
        if (d == 0 && wdo && wa == int'(rd_addr)) r = merge(r, wd, wbe);
      end
      e = {32'(cyc + lat - 1), r};
      if (d == 0) exp_q_a.push_back(e); else exp_q_b.push_back(e);
    end
    if (wdo) m_mem[d][wa] = merge(m_mem[d][wa], wd, wbe);
    if (m_clr_on[d]) begin
      if (m_clr_pos[d] == DEPTH - 1) m_clr_on[d] = 0;
      else m_clr_pos[d]++;
    end else if (clr_req) begin
      m_clr_on[d] = 1; m_clr_pos[d] = 0;
    end
    m_drop[d]  = ndrop;
    m_valid[d] = 0;
    if (d == 0) begin
      if (exp_q_a.size() > 0 && exp_q_a[0][63:32] == 32'(cyc)) begin
        e = exp_q_a.pop_front(); m_valid[d] = 1; m_data[d] = e[31:0];
      end
    end else begin
      if (exp_q_b.size() > 0 && exp_q_b[0][63:32] == 32'(cyc)) begin
        e = exp_q_b.pop_front(); m_valid[d] = 1; m_data[d] = e[31:0];
      end
    end
  endtask

  // Every cycle after reset: all outputs of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
      if (rst) started = 1;
      #1;
      if (started) begin
        chk("a_busy", 32'(bus_a.CLR_BUSY), 32'(m_clr_on[0]));
        chk("a_drop", 32'(bus_a.WR_DROP), 32'(m_drop[0]));
        chk("a_valid", 32'(bus_a.RD_VALID), 32'(m_valid[0]));
        chk("a_data", bus_a.RD_DATA, m_data[0]);
        chk("b_busy", 32'(bus_b.CLR_BUSY), 32'(m_clr_on[1]));
        chk("b_drop", 32'(bus_b.WR_DROP), 32'(m_drop[1]));
        chk("b_valid", 32'(bus_b.RD_VALID), 32'(m_valid[1]));
        chk("b_data", bus_b.RD_DATA, m_data[1]);
      end
    end
  end

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  function automatic logic busy_of(input int d);
    return (d == 0) ? bus_a.CLR_BUSY : bus_b.CLR_BUSY;
  endfunction

  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic fill_with_addr();
    for (int i = 0; i < DEPTH; i++) do_write(i, 32'(i), 4'hF);
  endtask

  task automatic count_busy(input int d, output int n);
    n = 0;
    while (busy_of(d) && n < 1100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_check(input int a, input logic [31:0] exp_a, input logic [31:0] exp_b,
                            input string name, input bit with_wr, input logic [31:0] wdat);
    int          ia, ib;
    logic [31:0] da, db;
    ia = -1; ib = -1; da = '0; db = '0;
    rd_en = 1; rd_addr = AW'(a);
    if (with_wr) begin
      wr_en = 1; wr_addr = AW'(a); wr_data = wdat; wr_be = 4'hF;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin rd_en = 0; wr_en = 0; end
      if (bus_a.RD_VALID && ia < 0) begin ia = i; da = bus_a.RD_DATA; end
      if (bus_b.RD_VALID && ib < 0) begin ib = i; db = bus_b.RD_DATA; end
    end
    chk({name, "_a_lat"}, 32'(ia), 32'd0);
    chk({name, "_b_lat"}, 32'(ib), 32'd1);
    chk({name, "_a_data"}, da, exp_a);
    chk({name, "_b_data"}, db, exp_b);
  endtask

  task automatic sweep_count(output int ca, output int cb);
    ca = 0; cb = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rd_en = (i < DEPTH); rd_addr = (i < DEPTH) ? AW'(i) : '0;
      @(negedge clk);
      if (bus_a.RD_VALID && bus_a.RD_DATA == PAT) ca++;
      if (bus_b.RD_VALID && bus_b.RD_DATA == PAT) cb++;
    end
    rd_en = 0;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [31:0] pv [4];

  initial begin
    int n, ca, cb, got, first;
    bit saw_drop;
    for (int d = 0; d < 2; d++) for (int i = 0; i < DEPTH; i++) m_mem[d][i] = PAT;
    rst = 1; wr_en = 0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 0; rd_addr = '0; clr_req = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    chk("rst_a_rd_data", bus_a.RD_DATA, 32'd0);
    chk("rst_b_rd_data", bus_b.RD_DATA, 32'd0);
    chk("rst_a_rd_valid", 32'(bus_a.RD_VALID), 32'd0);
    chk("rst_a_wr_drop", 32'(bus_a.WR_DROP), 32'd0);
    chk("rst_a_clr_busy", 32'(bus_a.CLR_BUSY), 32'd0);
    chk("rst_b_clr_busy", 32'(bus_b.CLR_BUSY), 32'd1);
    count_busy(1, n);
    chk("reset_clear_len_b", 32'(n), 32'd1000);

    // Byte-enable merge
    do_write(5, 32'hDEADBEEF, 4'b1111);
    do_write(5, 32'h11223344, 4'b0101);
    read_check(5, 32'hDE22BE44, 32'hDE22BE44, "be_merge", 0, '0);

    // Same-address collision
    do_write(7, 32'hAAAAAAAA, 4'hF);
    read_check(7, 32'h12345678, 32'hAAAAAAAA, "collide", 1, 32'h12345678);
    read_check(7, 32'h12345678, 32'h12345678, "collide_after", 0, '0);

    // Out of range
    wr_en = 1; wr_addr = AW'(1000); wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    @(negedge clk);
    wr_en = 0;
    chk("oor_drop_a", 32'(bus_a.WR_DROP), 32'd1);
    chk("oor_drop_b", 32'(bus_b.WR_DROP), 32'd1);
    @(negedge clk);
    chk("oor_drop_one_cycle", 32'(bus_a.WR_DROP), 32'd0);
    read_check(1023, 32'd0, 32'd0, "oor_read", 0, '0);

    // Clear with a user write landing mid-clear
    fill_with_addr();
    read_check(999, 32'd999, 32'd999, "fill", 0, '0);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    n = 0; saw_drop = 0;
    while (bus_a.CLR_BUSY && n < 1100) begin
      if (n == 500) begin
        wr_en = 1; wr_addr = AW'(10); wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
      end else wr_en = 0;
      if (n == 501) saw_drop = bus_a.WR_DROP;
      n++;
      @(negedge clk);
    end
    wr_en = 0;
    chk("clear_len_a", 32'(n), 32'd1000);
    chk("clear_drop", 32'(saw_drop), 32'd1);
    chk("clear_done_b", 32'(bus_b.CLR_BUSY), 32'd0);
    sweep_count(ca, cb);
    chk("clear_sweep_a", 32'(ca), 32'd1000);
    chk("clear_sweep_b", 32'(cb), 32'd1000);
    read_check(10, PAT, PAT, "drop_no_effect", 0, '0);

    // Reset at clear count 300
    fill_with_addr();
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    repeat (300) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_a_idle", 32'(bus_a.CLR_BUSY), 32'd0);
    count_busy(1, n);
    chk("restart_len_b", 32'(n), 32'd1000);
    sweep_count(ca, cb);
    chk("restart_sweep_b", 32'(cb), 32'd1000);
    read_check(500, 32'd500, PAT, "abort_keeps", 0, '0);
    read_check(100, PAT, PAT, "abort_cleared", 0, '0);

    // Pipelined reads, latency 2
    for (int i = 0; i < 4; i++) begin
      pv[i] = $urandom;
      do_write(i, pv[i], 4'hF);
    end
    got = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin rd_en = 1; rd_addr = AW'(i); end else rd_en = 0;
      @(negedge clk);
      if (bus_b.RD_VALID) begin
        if (got < 4) chk($sformatf("pipe_b_%0d", got), bus_b.RD_DATA, pv[got]);
        if (got == 0) first = i;
        got++;
      end
      if (i >= 5) chk("pipe_b_hold", bus_b.RD_DATA, pv[3]);
    end
    chk("pipe_b_count", 32'(got), 32'd4);
    chk("pipe_b_first", 32'(first), 32'd1);

    // Random traffic, mostly on a small address window to force collisions
    for (int i = 0; i < 3000; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 15));
      wr_be   = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 1023)) : AW'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 999) == 0);
      rst     = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    rst = 0; wr_en = 0; rd_en = 0; clr_req = 0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_sdp_param.md
Name: bram_sdp_param

Overview:
Parametrised simple-dual-port block RAM: one write port, one read port, one clock. It is the successor to the fixed 2K x 8 single-port capture buffer and generalises width and depth. It adds byte enables, selectable read-during-write mode, 1- or 2-cycle read latency with a valid flag, and a hardware clear engine. Capture logic writes samples and the upload path reads them back.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8
DEPTH, 2048, number of words; need not be a power of two
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, WRITE_FIRST, read-during-write result for a same-address collision: WRITE_FIRST or READ_FIRST
INIT_PATTERN, 8'h5A, byte pattern replicated across the word; used for the initial contents and by the clear engine
CLEAR_ON_RESET, 1, when 1, reset launches a full clear

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous active-high
WR_EN  in  1  write request
WR_ADDR  in  ADDR_W  write address
WR_BE  in  DATA_W/8  byte enables; bit i covers WR_DATA[8i+7:8i]
WR_DATA  in  DATA_W  write data
WR_DROP  out  1  one-cycle pulse: a write was discarded (clear busy or address out of range)
RD_EN  in  1  read request
RD_ADDR  in  ADDR_W  read address
RD_DATA  out  DATA_W  read data; holds its last value between reads
RD_VALID  out  1  pulses high when RD_DATA carries a new read result
CLR_REQ  in  1  request a full-memory clear
CLR_BUSY  out  1  high while the clear engine owns the write port

Behaviour:
- Reset values: RD_DATA=0, RD_VALID=0, WR_DROP=0. CLR_BUSY becomes 1 on the cycle after RST if CLEAR_ON_RESET=1, otherwise 0. Reset never alters array contents directly.
- Array initial contents: every word equals INIT_PATTERN replicated.
- Write: on a rising edge with WR_EN=1, CLR_BUSY=0 and WR_ADDR<DEPTH, each byte whose WR_BE bit is 1 is updated. WR_BE=0 is a legal no-op and does not assert WR_DROP.
- Read: with RD_EN=1 at edge N, RD_DATA and RD_VALID update at edge N+RD_LATENCY. RD_VALID is high for exactly one cycle per accepted read. Back-to-back reads are fully pipelined, one result per cycle.
- Reads are allowed during a clear and return the array as it stands.
- Read of an address at or above DEPTH: RD_VALID still pulses and RD_DATA=0.
- Same-address collision at one edge: WRITE_FIRST returns the merged word (new bytes where WR_BE=1, old bytes elsewhere); READ_FIRST returns the pre-write word.
- RD_LATENCY=2: a second register stage sits on data and valid. A stage-1 result is forwarded even when RD_EN has since dropped.
- Clear FSM states: IDLE and CLEARING.
  - IDLE -> CLEARING on CLR_REQ=1 at an edge; address counter set to 0.
  - CLEARING: writes INIT_PATTERN to counter address, all bytes, one word per cycle.
  - CLEARING -> IDLE after the write to DEPTH-1. CLR_BUSY is high for exactly DEPTH cycles.
  - CLR_REQ while CLEARING is ignored.
- A user write during CLEARING is discarded and WR_DROP pulses on the next cycle. An out-of-range user write also pulses WR_DROP.
- RST during CLEARING aborts the clear and clears the counter. If CLEAR_ON_RESET=1 the clear restarts from address 0, otherwise the FSM returns to IDLE.
- RST flushes the read pipeline: in-flight results are lost and RD_VALID=0.
- Elaboration error if DATA_W%8≠0, RD_LATENCY∉{1,2}, or DEPTH<2.

Decomposition:
- Package bram_pkg holds the rdw_mode_e enum {WRITE_FIRST, READ_FIRST}, clr_state_e {IDLE, CLEARING}, and a replicate-pattern function.
- Sub-module bram_clear_fsm holds the clear state, the address counter and the CLR_BUSY output. It drives a write-port override mux in the top.
- Array, byte-enable merge and read pipeline stay in the top.

Test Plan:
- DATA_W=32, DEPTH=1000, CLEAR_ON_RESET=0: write 0xDEADBEEF to 5 with BE=4'b1111, then 0x11223344 to 5 with BE=4'b0101. Read 5 -> 0xDE22BE44, with RD_VALID one cycle after RD_EN (two cycles when RD_LATENCY=2).
- Collision: word 7 holds 0xAAAAAAAA; write 0x12345678, BE=4'b1111, and read 7 at the same edge. WRITE_FIRST -> 0x12345678; READ_FIRST -> 0xAAAAAAAA.
- Clear: fill 0..999 with the address value, pulse CLR_REQ. CLR_BUSY is high for exactly 1000 cycles. A user write issued during the clear gives a WR_DROP pulse and the array is unchanged by it. After the clear, reading all 1000 words -> 0x5A5A5A5A.
- Reset mid-clear: assert RST at clear count 300 with CLEAR_ON_RESET=1. CLR_BUSY restarts and stays high for a further 1000 cycles; all words end at 0x5A5A5A5A.
- Pipelined reads: RD_EN on 4 consecutive cycles at addresses 0..3 with RD_LATENCY=2. Four consecutive RD_VALID pulses arrive in order, and RD_DATA then holds the last value while RD_EN=0.
- Out of range: write to 1000 -> WR_DROP pulses and no array change. Read 1023 -> RD_VALID pulses with RD_DATA=0.
